// File: rtl/rs_rx_delimiter_pkg.sv
// Shared constants and FSM state type for the GMII receive delimiter.
package rs_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] FALSE_CARRIER = 8'h0E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rs_rx_delimiter_if.sv
// GMII receive inputs and MAC-side payload outputs of rs_rx_delimiter, bundled.
interface rs_rx_delimiter_if;

  logic [7:0] rxd;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] mac_data;
  logic       mac_valid;
  logic       mac_sof;
  logic       mac_eof;
  logic       mac_err;
  logic       false_carrier;

  modport master (
    output rxd, rx_dv, rx_er,
    input  mac_data, mac_valid, mac_sof, mac_eof, mac_err, false_carrier
  );

  modport slave (
    input  rxd, rx_dv, rx_er,
    output mac_data, mac_valid, mac_sof, mac_eof, mac_err, false_carrier
  );

endinterface

// File: rtl/rs_rx_delimiter_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module rs_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rs_rx_delimiter.sv
// GMII receive delimiter: validates and strips preamble/SFD, delivers payload
// bytes with sof/eof/err to the MAC, flags false carrier and counts frames.
module rs_rx_delimiter
  import rs_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MAX_LEN      = 1522,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             rx_clk,
  input  logic             reset_n,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       mac_data,
  output logic             mac_valid,
  output logic             mac_sof,
  output logic             mac_eof,
  output logic             mac_err,
  output logic             false_carrier,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [7:0]       rxd_q;
  logic             dv_q, er_q;
  rx_state_e        state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             err_acc_q, err_acc_d;
  logic             first_q, first_d;
  logic [7:0]       mac_data_q, mac_data_d;
  logic             mac_valid_q, mac_valid_d;
  logic             mac_sof_q, mac_sof_d;
  logic             mac_eof_q, mac_eof_d;
  logic             mac_err_q, mac_err_d;
  logic             fc_q, fc_d;
  logic             inc_ok, inc_err;

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    len_d        = len_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    err_acc_d    = err_acc_q;
    first_d      = first_q;
    mac_data_d   = '0;
    mac_valid_d  = 1'b0;
    mac_sof_d    = 1'b0;
    mac_eof_d    = 1'b0;
    mac_err_d    = 1'b0;
    fc_d         = 1'b0;
    inc_ok       = 1'b0;
    inc_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv_q) begin
          if (!er_q && rxd_q == PREAMBLE_BYTE) begin
            state_d = PREAMBLE;
            pcnt_d  = 3'd1;
          end else if (rxd_q == SFD_BYTE && MIN_PREAMBLE == 0) begin
            state_d = DATA;
            len_d   = '0;
            first_d = 1'b1;
          end else begin
            state_d = DROP;
            inc_err = 1'b1;
          end
        end else if (er_q && rxd_q == FALSE_CARRIER) begin
          fc_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_d = IDLE;
          inc_err = 1'b1;
        end else if (!er_q && rxd_q == PREAMBLE_BYTE) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if (!er_q && rxd_q == SFD_BYTE && 32'(pcnt_q) >= MIN_PREAMBLE) begin
          state_d = DATA;
          len_d   = '0;
          first_d = 1'b1;
        end else begin
          state_d = DROP;
          inc_err = 1'b1;
        end
      end
      DATA: begin
        // Each byte is held one cycle so the last one can carry eof when dv falls.
        if (dv_q && len_q == LEN_W'(MAX_LEN)) begin
          mac_valid_d  = 1'b1;
          mac_data_d   = hold_q;
          mac_sof_d    = first_q;
          mac_eof_d    = 1'b1;
          mac_err_d    = 1'b1;
          inc_err      = 1'b1;
          hold_valid_d = 1'b0;
          err_acc_d    = 1'b0;
          first_d      = 1'b0;
          state_d      = DROP;
        end else if (dv_q) begin
          if (hold_valid_q) begin
            mac_valid_d = 1'b1;
            mac_data_d  = hold_q;
            mac_sof_d   = first_q;
            first_d     = 1'b0;
          end
          hold_d       = rxd_q;
          hold_valid_d = 1'b1;
          len_d        = len_q + 1'b1;
          err_acc_d    = err_acc_q | er_q;
        end else begin
          if (hold_valid_q) begin
            mac_valid_d = 1'b1;
            mac_data_d  = hold_q;
            mac_sof_d   = first_q;
            mac_eof_d   = 1'b1;
            mac_err_d   = err_acc_q;
            inc_ok      = !err_acc_q;
            inc_err     = err_acc_q;
          end else begin
            inc_err = 1'b1;
          end
          hold_valid_d = 1'b0;
          err_acc_d    = 1'b0;
          first_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      DROP: begin
        if (!dv_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_q        <= '0;
      dv_q         <= 1'b0;
      er_q         <= 1'b0;
      state_q      <= IDLE;
      pcnt_q       <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      err_acc_q    <= 1'b0;
      first_q      <= 1'b0;
      mac_data_q   <= '0;
      mac_valid_q  <= 1'b0;
      mac_sof_q    <= 1'b0;
      mac_eof_q    <= 1'b0;
      mac_err_q    <= 1'b0;
      fc_q         <= 1'b0;
    end else begin
      rxd_q        <= rxd;
      dv_q         <= rx_dv;
      er_q         <= rx_er;
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      err_acc_q    <= err_acc_d;
      first_q      <= first_d;
      mac_data_q   <= mac_data_d;
      mac_valid_q  <= mac_valid_d;
      mac_sof_q    <= mac_sof_d;
      mac_eof_q    <= mac_eof_d;
      mac_err_q    <= mac_err_d;
      fc_q         <= fc_d;
    end
  end

  rs_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk     (rx_clk),
    .reset_n (reset_n),
    .inc     (inc_ok),
    .count   (frames_ok)
  );

  rs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (rx_clk),
    .reset_n (reset_n),
    .inc     (inc_err),
    .count   (frames_err)
  );

  assign mac_data      = mac_data_q;
  assign mac_valid     = mac_valid_q;
  assign mac_sof       = mac_sof_q;
  assign mac_eof       = mac_eof_q;
  assign mac_err       = mac_err_q;
  assign false_carrier = fc_q;

endmodule

// File: tb/tb_rs_rx_delimiter.sv
// Randomized self-checking bench: two delimiters (full MAX_LEN/16-bit counters,
// MAX_LEN=4/2-bit counters) share one GMII stream and are checked against a frame-level model.
module tb_rs_rx_delimiter;
  import rs_pkg::*;

  localparam int MAX_A = 1522;
  localparam int MAX_B = 4;
  localparam int MIN_P = 1;

  typedef struct packed { logic [7:0] d; logic er; } rxb_t;
  typedef struct packed { logic [7:0] d; logic sof; logic eof; logic err; } beat_t;

  logic rx_clk  = 1'b0;
  logic reset_n = 1'b0;
  always #4 rx_clk = ~rx_clk;

  rs_rx_delimiter_if bus_a ();
  rs_rx_delimiter_if bus_b ();
  logic [15:0] ok_a, err_a;
  logic [1:0]  ok_b, err_b;

  assign bus_b.rxd   = bus_a.rxd;
  assign bus_b.rx_dv = bus_a.rx_dv;
  assign bus_b.rx_er = bus_a.rx_er;

  rs_rx_delimiter #(.MIN_PREAMBLE(MIN_P), .MAX_LEN(MAX_A), .CNT_W(16)) dut_a (
    .rx_clk(rx_clk), .reset_n(reset_n),
    .rxd(bus_a.rxd), .rx_dv(bus_a.rx_dv), .rx_er(bus_a.rx_er),
    .mac_data(bus_a.mac_data), .mac_valid(bus_a.mac_valid), .mac_sof(bus_a.mac_sof),
    .mac_eof(bus_a.mac_eof), .mac_err(bus_a.mac_err), .false_carrier(bus_a.false_carrier),
    .frames_ok(ok_a), .frames_err(err_a)
  );

  rs_rx_delimiter #(.MIN_PREAMBLE(MIN_P), .MAX_LEN(MAX_B), .CNT_W(2)) dut_b (
    .rx_clk(rx_clk), .reset_n(reset_n),
    .rxd(bus_b.rxd), .rx_dv(bus_b.rx_dv), .rx_er(bus_b.rx_er),
    .mac_data(bus_b.mac_data), .mac_valid(bus_b.mac_valid), .mac_sof(bus_b.mac_sof),
    .mac_eof(bus_b.mac_eof), .mac_err(bus_b.mac_err), .false_carrier(bus_b.false_carrier),
    .frames_ok(ok_b), .frames_err(err_b)
  );

  int edge_n = 0;
  always @(posedge rx_clk) edge_n <= edge_n + 1;

  beat_t cap_a[$];
  beat_t cap_b[$];
  int    cap_a_edge[$];
  int    fc_a = 0, fc_b = 0, idle_bad = 0;

  always @(negedge rx_clk) begin
    if (bus_a.mac_valid) begin
      cap_a.push_back({bus_a.mac_data, bus_a.mac_sof, bus_a.mac_eof, bus_a.mac_err});
      cap_a_edge.push_back(edge_n);
    end else if (bus_a.mac_sof || bus_a.mac_eof || bus_a.mac_err) begin
      idle_bad++;
    end
    if (bus_b.mac_valid)
      cap_b.push_back({bus_b.mac_data, bus_b.mac_sof, bus_b.mac_eof, bus_b.mac_err});
    else if (bus_b.mac_sof || bus_b.mac_eof || bus_b.mac_err)
      idle_bad++;
    if (bus_a.false_carrier) fc_a++;
    if (bus_b.false_carrier) fc_b++;
  end

  int errors = 0, checks = 0;
  int exp_ok_a = 0, exp_err_a = 0, exp_ok_b = 0, exp_err_b = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  int sa, sb;
  int drv_edge[$];

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic rxb_t mk(input logic [7:0] d, input logic er);
    return {d, er};
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    bus_a.rxd   = d;
    bus_a.rx_dv = dv;
    bus_a.rx_er = er;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Frame-level view: leading clean 0x55s, then an SFD, then payload truncated at max_len.
  task automatic model(input rxb_t fr[$], input int max_len, output beat_t bq[$],
                       output int ok_inc, output int err_inc);
    int    k, n, p, nb;
    bit    start_ok;
    logic  anyer;
    beat_t b;
    bq.delete();
    ok_inc = 0;
    err_inc = 0;
    n = fr.size();
    k = 0;
    while (k < n && fr[k].d == PREAMBLE_BYTE && !fr[k].er) k++;
    if (k == n) begin err_inc = 1; return; end
    if (k == 0) start_ok = (fr[0].d == SFD_BYTE) && (MIN_P == 0);
    else        start_ok = (fr[k].d == SFD_BYTE) && !fr[k].er && (((k > 7) ? 7 : k) >= MIN_P);
    if (!start_ok) begin err_inc = 1; return; end
    p = n - (k + 1);
    if (p == 0) begin err_inc = 1; return; end
    nb = (p > max_len) ? max_len : p;
    anyer = 1'b0;
    for (int i = 0; i < p; i++) anyer = anyer | fr[k + 1 + i].er;
    for (int i = 0; i < nb; i++) begin
      b = {fr[k + 1 + i].d, (i == 0), (i == nb - 1), 1'b0};
      bq.push_back(b);
    end
    if (p > max_len) begin
      bq[nb - 1].err = 1'b1;
      err_inc = 1;
    end else begin
      bq[nb - 1].err = anyer;
      if (anyer) err_inc = 1;
      else       ok_inc = 1;
    end
  endtask

  task automatic mark();
    sa = cap_a.size();
    sb = cap_b.size();
    exp_a.delete();
    exp_b.delete();
    drv_edge.delete();
  endtask

  task automatic run_frame(input rxb_t fr[$], input int gap);
    beat_t qa[$];
    beat_t qb[$];
    int oa, ea, ob, eb;
    model(fr, MAX_A, qa, oa, ea);
    model(fr, MAX_B, qb, ob, eb);
    foreach (qa[i]) exp_a.push_back(qa[i]);
    foreach (qb[i]) exp_b.push_back(qb[i]);
    exp_ok_a += oa; exp_err_a += ea;
    exp_ok_b += ob; exp_err_b += eb;
    foreach (fr[i]) begin
      drive(fr[i].d, 1'b1, fr[i].er);
      drv_edge.push_back(edge_n);
    end
    for (int i = 0; i < gap; i++) drive(8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic std_frame(output rxb_t fr[$], input int npay, input logic [7:0] base, input int er_idx);
    fr.delete();
    repeat (7) fr.push_back(mk(PREAMBLE_BYTE, 1'b0));
    fr.push_back(mk(SFD_BYTE, 1'b0));
    for (int i = 0; i < npay; i++) fr.push_back(mk(base + 8'(i), (i == er_idx)));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_a.rxd = 8'h00; bus_a.rx_dv = 1'b0; bus_a.rx_er = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    checks++;
    if ({bus_a.mac_valid, bus_a.mac_sof, bus_a.mac_eof, bus_a.mac_err, bus_a.false_carrier} !== 5'b0 ||
        bus_a.mac_data !== 8'h00 || ok_a !== 16'd0 || err_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_a got valid=%b data=%h ok=%0d err=%0d exp all zero",
               bus_a.mac_valid, bus_a.mac_data, ok_a, err_a);
    end
    checks++;
    if ({bus_b.mac_valid, bus_b.mac_sof, bus_b.mac_eof, bus_b.mac_err, bus_b.false_carrier} !== 5'b0 ||
        bus_b.mac_data !== 8'h00 || ok_b !== 2'd0 || err_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_b got valid=%b data=%h ok=%0d err=%0d exp all zero",
               bus_b.mac_valid, bus_b.mac_data, ok_b, err_b);
    end
    reset_n = 1'b1;
    settle();
  endtask

  task automatic check_scenario(input string name);
    checks++;
    if (cap_a.size() - sa !== exp_a.size()) begin
      errors++;
      $display("FAIL %s beats_a got=%0d exp=%0d", name, cap_a.size() - sa, exp_a.size());
    end else begin
      foreach (exp_a[i]) begin
        checks++;
        if (cap_a[sa + i] !== exp_a[i]) begin
          errors++;
          $display("FAIL %s beat_a[%0d] got d=%h sof=%b eof=%b err=%b exp d=%h sof=%b eof=%b err=%b",
                   name, i, cap_a[sa+i].d, cap_a[sa+i].sof, cap_a[sa+i].eof, cap_a[sa+i].err,
                   exp_a[i].d, exp_a[i].sof, exp_a[i].eof, exp_a[i].err);
        end
      end
    end
    checks++;
    if (cap_b.size() - sb !== exp_b.size()) begin
      errors++;
      $display("FAIL %s beats_b got=%0d exp=%0d", name, cap_b.size() - sb, exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        checks++;
        if (cap_b[sb + i] !== exp_b[i]) begin
          errors++;
          $display("FAIL %s beat_b[%0d] got d=%h sof=%b eof=%b err=%b exp d=%h sof=%b eof=%b err=%b",
                   name, i, cap_b[sb+i].d, cap_b[sb+i].sof, cap_b[sb+i].eof, cap_b[sb+i].err,
                   exp_b[i].d, exp_b[i].sof, exp_b[i].eof, exp_b[i].err);
        end
      end
    end
    checks++;
    if (ok_a !== 16'(exp_ok_a) || err_a !== 16'(exp_err_a) ||
        ok_b !== 2'(sat(exp_ok_b)) || err_b !== 2'(sat(exp_err_b))) begin
      errors++;
      $display("FAIL %s counters got ok_a=%0d err_a=%0d ok_b=%0d err_b=%0d exp %0d %0d %0d %0d",
               name, ok_a, err_a, ok_b, err_b, exp_ok_a, exp_err_a, sat(exp_ok_b), sat(exp_err_b));
    end
  endtask

  task automatic test_basic();
    rxb_t fr[$];
    mark();
    std_frame(fr, 4, 8'h01, -1);
    run_frame(fr, 1);
    settle();
    check_scenario("basic");
    checks++;
    if (cap_a_edge.size() <= sa || cap_a_edge[sa] !== drv_edge[8] + 2) begin
      errors++;
      $display("FAIL basic_latency got edge=%0d exp=%0d",
               (cap_a_edge.size() > sa) ? cap_a_edge[sa] : -1, drv_edge[8] + 2);
    end
  endtask

  task automatic test_rx_er();
    rxb_t fr[$];
    mark();
    std_frame(fr, 4, 8'h01, 1);
    run_frame(fr, 1);
    settle();
    check_scenario("rx_er");
  endtask

  task automatic test_no_preamble();
    rxb_t fr[$];
    mark();
    fr.delete();
    repeat (3) fr.push_back(mk(8'h4F, 1'b0));
    run_frame(fr, 1);
    std_frame(fr, 3, 8'h30, -1);
    run_frame(fr, 1);
    settle();
    check_scenario("no_preamble");
  endtask

  task automatic test_false_carrier();
    int fa, fb;
    mark();
    fa = fc_a; fb = fc_b;
    repeat (2) drive(FALSE_CARRIER, 1'b0, 1'b1);
    settle();
    checks++;
    if (fc_a - fa !== 2 || fc_b - fb !== 2) begin
      errors++;
      $display("FAIL false_carrier_pulse got a=%0d b=%0d exp=2", fc_a - fa, fc_b - fb);
    end
    fa = fc_a; fb = fc_b;
    repeat (2) drive(8'h0F, 1'b0, 1'b1);
    settle();
    checks++;
    if (fc_a - fa !== 0 || fc_b - fb !== 0) begin
      errors++;
      $display("FAIL carrier_extend_pulse got a=%0d b=%0d exp=0", fc_a - fa, fc_b - fb);
    end
    check_scenario("false_carrier");
  endtask

  task automatic test_max_len();
    rxb_t fr[$];
    mark();
    std_frame(fr, 6, 8'h10, -1);
    run_frame(fr, 1);
    settle();
    check_scenario("max_len");
  endtask

  task automatic test_back_to_back();
    rxb_t fr[$];
    mark();
    std_frame(fr, 2, 8'h60, -1);
    run_frame(fr, 1);
    std_frame(fr, 3, 8'h70, 2);
    run_frame(fr, 1);
    std_frame(fr, 1, 8'h80, -1);
    run_frame(fr, 1);
    settle();
    check_scenario("back_to_back");
  endtask

  task automatic test_random();
    rxb_t fr[$];
    int npre, plen, fa, fb;
    mark();
    fa = fc_a; fb = fc_b;
    for (int f = 0; f < 60; f++) begin
      fr.delete();
      npre = $urandom_range(0, 8);
      for (int i = 0; i < npre; i++)
        fr.push_back(mk(PREAMBLE_BYTE, ($urandom_range(0, 19) == 0)));
      if ($urandom_range(0, 9) != 0) fr.push_back(mk(SFD_BYTE, ($urandom_range(0, 19) == 0)));
      else                           fr.push_back(mk(8'($urandom), 1'b0));
      plen = $urandom_range(0, 7);
      for (int i = 0; i < plen; i++)
        fr.push_back(mk(8'($urandom), ($urandom_range(0, 15) == 0)));
      run_frame(fr, $urandom_range(1, 3));
    end
    settle();
    check_scenario("random");
    checks++;
    if (fc_a != fa || fc_b != fb) begin
      errors++;
      $display("FAIL random_false_carrier got a=%0d b=%0d exp=0", fc_a - fa, fc_b - fb);
    end
  endtask

  task automatic test_reset_mid();
    rxb_t fr[$];
    int s0, eofs;
    s0 = cap_a.size();
    repeat (7) drive(PREAMBLE_BYTE, 1'b1, 1'b0);
    drive(SFD_BYTE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'h11 * 8'(i + 1), 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_a.mac_valid !== 1'b0 || bus_a.mac_eof !== 1'b0 || bus_a.mac_data !== 8'h00 ||
        bus_b.mac_valid !== 1'b0 || ok_a !== 16'd0 || err_a !== 16'd0 || ok_b !== 2'd0 || err_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got valid_a=%b data_a=%h valid_b=%b ok_a=%0d err_a=%0d exp zero",
               bus_a.mac_valid, bus_a.mac_data, bus_b.mac_valid, ok_a, err_a);
    end
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    exp_ok_a = 0; exp_err_a = 0; exp_ok_b = 0; exp_err_b = 0;
    eofs = 0;
    for (int i = s0; i < cap_a.size(); i++) if (cap_a[i].eof) eofs++;
    checks++;
    if (eofs !== 0) begin
      errors++;
      $display("FAIL reset_mid_eof got=%0d exp=0", eofs);
    end
    mark();
    std_frame(fr, 1, 8'hAA, -1);
    run_frame(fr, 1);
    settle();
    check_scenario("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rx_er();
    test_no_preamble();
    test_false_carrier();
    test_max_len();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL flags_without_valid got=%0d exp=0", idle_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
